// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller with per-scan debounce and a CPU-readable key store.
// Build option KEYPAD_FIFO_EN: 4-entry FIFO store instead of a single holding register.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 25000,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] rowwrite,
    input  logic [3:0] colread,
    input  logic       ack,
    input  logic       statusordata,
    output logic [3:0] keyout
);
    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE);
    localparam bit DebOne = (DEBOUNCE <= 1);

    typedef enum logic [1:0] {StIdle, StDebounce, StHeld} state_e;

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      row_q, row_d;
    logic            acc_hit_q, acc_hit_d;
    logic [3:0]      acc_code_q, acc_code_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic            ack_q;

    logic       row_last, scan_last;
    logic       col_hit;
    logic [1:0] col_idx;
    logic       scan_hit;
    logic [3:0] scan_code;
    logic       capture;
    logic       ack_edge;
    logic       drop;
    logic       valid;
    logic [3:0] head;
    logic       overrun_q, overrun_d;

    assign row_last  = (div_q == DivLast);
    assign scan_last = row_last && (row_q == 2'd3);
    assign rowwrite  = ~(4'b0001 << row_q);
    assign ack_edge  = ack && !ack_q;
    assign cnt_inc   = cnt_q + CntW'(1);

    always_comb begin
        div_d = div_q + DivW'(1);
        row_d = row_q;
        if (row_last) begin
            div_d = '0;
            row_d = row_q + 2'd1;
        end
    end

    // Lowest low column wins.
    always_comb begin
        col_hit = 1'b0;
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!colread[i]) begin
                col_hit = 1'b1;
                col_idx = 2'(i);
            end
        end
    end

    // First hit of the scan is kept; the final row's sample is folded in at scan end.
    always_comb begin
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (row_last && col_hit && !acc_hit_q) begin
            acc_hit_d  = 1'b1;
            acc_code_d = {row_q, col_idx};
        end
        if (scan_last) begin
            acc_hit_d  = 1'b0;
            acc_code_d = 4'h0;
        end
    end

    assign scan_hit  = acc_hit_q || col_hit;
    assign scan_code = acc_hit_q ? acc_code_q : {row_q, col_idx};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        capture = 1'b0;
        if (scan_last) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_hit) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                        if (DebOne) begin
                            capture = 1'b1;
                            state_d = StHeld;
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (!scan_hit) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (scan_code != cand_q) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) begin
                            capture = 1'b1;
                            state_d = StHeld;
                        end
                    end
                end
                StHeld: begin
                    if (!scan_hit) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            row_q      <= 2'd0;
            acc_hit_q  <= 1'b0;
            acc_code_q <= 4'h0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            cand_q     <= 4'h0;
            ack_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            row_q      <= row_d;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            ack_q      <= ack;
            overrun_q  <= overrun_d;
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [3:0] mem_q [4];
    logic [1:0] rd_q, rd_d, wr_q, wr_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       wr_en;

    // Pop is applied before the push so a same-cycle capture can use the freed slot.
    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        fcnt_d = fcnt_q;
        drop   = 1'b0;
        wr_en  = 1'b0;
        if (ack_edge && (fcnt_q != 3'd0)) begin
            rd_d   = rd_q + 2'd1;
            fcnt_d = fcnt_q - 3'd1;
        end
        if (capture) begin
            if (fcnt_d == 3'd4) begin
                drop = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_d   = wr_q + 2'd1;
                fcnt_d = fcnt_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= 2'd0;
            wr_q   <= 2'd0;
            fcnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 4'h0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fcnt_q <= fcnt_d;
            if (wr_en) mem_q[wr_q] <= scan_code;
        end
    end

    assign valid = (fcnt_q != 3'd0);
    assign head  = mem_q[rd_q];
`else
    logic [3:0] hold_q, hold_d;
    logic       occ_q, occ_d;

    always_comb begin
        hold_d = hold_q;
        occ_d  = occ_q;
        drop   = 1'b0;
        if (ack_edge) occ_d = 1'b0;
        if (capture) begin
            if (occ_d) begin
                drop = 1'b1;
            end else begin
                hold_d = scan_code;
                occ_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= 4'h0;
            occ_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            occ_q  <= occ_d;
        end
    end

    assign valid = occ_q;
    assign head  = hold_q;
`endif

    always_comb begin
        overrun_d = overrun_q;
        if (ack_edge) overrun_d = 1'b0;
        if (drop) overrun_d = 1'b1;
    end

    assign keyout = statusordata ? {2'b00, overrun_q, valid} : (valid ? head : 4'h0);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and an expected-code queue.
module tb_keypad_scanner;
    localparam int unsigned ScanDiv = 4;
    localparam int unsigned Deb = 3;
    localparam int unsigned ScanLen = 4 * ScanDiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ack = 1'b0;
    logic        statusordata = 1'b0;
    logic [3:0]  rowwrite, colread, keyout;
    logic [15:0] keys = 16'h0000;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_q[$];

    keypad_scanner #(.SCAN_DIV(ScanDiv), .DEBOUNCE(Deb)) dut (
        .clk(clk),
        .reset(reset),
        .rowwrite(rowwrite),
        .colread(colread),
        .ack(ack),
        .statusordata(statusordata),
        .keyout(keyout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pressed key (bit r*4+c) pulls column c low while row r is driven low.
    always_comb begin
        colread = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rowwrite[r] && keys[r*4+c]) colread[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [3:0] exp);
        statusordata = 1'b1;
        #1;
        check(tag, keyout, exp);
    endtask

    task automatic chk_data(input string tag, input logic [3:0] exp);
        statusordata = 1'b0;
        #1;
        check(tag, keyout, exp);
    endtask

    task automatic align();
        do @(negedge clk); while (cyc % ScanLen != 0);
    endtask

    task automatic scans(input int n);
        repeat (n) align();
    endtask

    task automatic pop(input string tag, input logic [3:0] st_after);
        logic [3:0] e;
        e = 4'h0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk_data({tag, "_data"}, e);
        ack = 1'b1;
        @(negedge clk);
        chk_status({tag, "_status"}, st_after);
        ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_row;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_row", rowwrite, 4'b1110);
        chk_status("reset_status", 4'b0000);
        chk_data("reset_data", 4'h0);

        for (int i = 0; i < 20; i++) begin
            exp_row = ~(4'b0001 << ((cyc / ScanDiv) % 4));
            check("row_sweep", rowwrite, exp_row);
            @(negedge clk);
        end

        // Single key row1/col2 held for four scans.
        align();
        keys = 16'h0040;
        exp_q.push_back(4'h6);
        scans(2);
        chk_status("deb_two_scans", 4'b0000);
        scans(1);
        chk_status("cap_status", 4'b0001);
        chk_data("cap_data", 4'h6);
        scans(1);
        chk_status("one_capture", 4'b0001);
        keys = 16'h0000;
        scans(1);

        // Long ack pulse pops once.
        chk_data("ack_hold_data", exp_q.pop_front());
        ack = 1'b1;
        @(negedge clk);
        chk_status("ack_edge_status", 4'b0000);
        repeat (9) @(negedge clk);
        chk_status("ack_held_status", 4'b0000);
        chk_data("ack_held_data", 4'h0);
        ack = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk_status("ack_empty", 4'b0000);

        // Bounce: hit, miss, hit, hit, hit.
        align();
        keys = 16'h0800;
        scans(1);
        keys = 16'h0000;
        scans(1);
        keys = 16'h0800;
        scans(2);
        chk_status("bounce_pre", 4'b0000);
        exp_q.push_back(4'hB);
        scans(1);
        chk_status("bounce_cap", 4'b0001);
        keys = 16'h0000;
        scans(1);
        pop("bounce_pop", 4'b0000);

        // Several columns in one row: lowest column wins.
        align();
        keys = 16'h20A0;
        exp_q.push_back(4'h5);
        scans(3);
        chk_status("multi_col_cap", 4'b0001);
        keys = 16'h0000;
        scans(1);
        pop("multi_col_pop", 4'b0000);

        // Several rows (code 3 and 12): lowest row wins; then 9 arrives before ack.
        align();
        keys = 16'h1008;
        exp_q.push_back(4'h3);
        scans(3);
        keys = 16'h0000;
        scans(1);
        keys = 16'h0200;
        scans(3);
        keys = 16'h0000;
        scans(1);
`ifdef KEYPAD_FIFO_EN
        exp_q.push_back(4'h9);
        chk_status("second_status", 4'b0001);
        pop("second_pop1", 4'b0001);
        pop("second_pop2", 4'b0000);
`else
        chk_status("overrun_status", 4'b0011);
        pop("overrun_pop", 4'b0000);
`endif

        // Capture and ack edge on the same clock.
        align();
        keys = 16'h0002;
        exp_q.push_back(4'h1);
        scans(3);
        keys = 16'h0000;
        scans(1);
        keys = 16'h0004;
        scans(2);
        do @(negedge clk); while (cyc % ScanLen != ScanLen - 1);
        chk_data("same_cycle_pre", exp_q.pop_front());
        ack = 1'b1;
        exp_q.push_back(4'h2);
        @(negedge clk);
        chk_status("same_cycle_status", 4'b0001);
        chk_data("same_cycle_data", exp_q[0]);
        ack = 1'b0;
        keys = 16'h0000;
        scans(1);

        // Reset mid-debounce with a stored key; key stays pressed through reset.
        align();
        keys = 16'h0010;
        scans(1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_row", rowwrite, 4'b1110);
        chk_status("mid_reset_status", 4'b0000);
        exp_q.delete();
        reset = 1'b0;
        exp_q.push_back(4'h4);
        scans(2);
        chk_status("post_reset_deb", 4'b0000);
        scans(1);
        chk_status("post_reset_cap", 4'b0001);
        chk_data("post_reset_data", exp_q[0]);
        scans(3);
        chk_status("post_reset_once", 4'b0001);
        keys = 16'h0000;
        scans(1);
        pop("post_reset_pop", 4'b0000);

`ifdef KEYPAD_FIFO_EN
        // Five captures into four slots.
        for (int k = 1; k <= 5; k++) begin
            align();
            keys = 16'h0001 << k;
            if (k <= 4) exp_q.push_back(4'(k));
            scans(3);
            keys = 16'h0000;
            scans(1);
        end
        chk_status("fifo_full_status", 4'b0011);
        pop("fifo_pop1", 4'b0001);
        pop("fifo_pop2", 4'b0001);
        pop("fifo_pop3", 4'b0001);
        pop("fifo_pop4", 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, meaning clk cycles each keypad row is driven.
REQ-002 SHALL have parameter DEBOUNCE, default 3, meaning consecutive full scans a key must be seen before capture.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rowwrite  output  4  active-low one-hot row drive to the keypad matrix.
REQ-006 SHALL have port colread  input  4  active-low column sense from the keypad matrix.
REQ-007 SHALL have port ack  input  1  level from the bus decoder, high while the CPU reads the data address.
REQ-008 SHALL have port statusordata  input  1  1 selects the status word, 0 selects the data word on keyout.
REQ-009 SHALL have port keyout  output  4  status or key code, selected combinationally by statusordata.

Function
REQ-010 SHALL drive rowwrite through 4'b1110, 4'b1101, 4'b1011, 4'b0111 cyclically, SCAN_DIV cycles per row, then wrap to 4'b1110.
REQ-011 SHALL sample colread once per row, on the last cycle of that row's period.
REQ-012 SHALL form key code = row_index*4 + col_index (row 0 = rowwrite bit 0, col 0 = colread bit 0), range 0..15.
REQ-013 SHALL, when several columns or rows are low in one scan, take the first hit in scan order: lowest row, then lowest column.
REQ-014 SHALL run debounce FSM states IDLE, DEBOUNCE, HELD.
REQ-015 SHALL move IDLE->DEBOUNCE on a hit, resetting the count to 1 and latching the candidate code.
REQ-016 SHALL increment the count in DEBOUNCE for each full scan with the same code; a different code restarts the count with the new candidate; a scan with no hit returns to IDLE.
REQ-017 SHALL, when the count reaches DEBOUNCE, capture the code into the holding store and enter HELD; capture is exactly one event per press.
REQ-018 SHALL remain in HELD until one full scan with no hit, then enter IDLE; no auto-repeat.
REQ-019 SHALL output status keyout = {2'b00, overrun, valid} when statusordata=1.
REQ-020 SHALL output data keyout = oldest stored code when statusordata=0 and valid=1, else 4'h0.
REQ-021 SHALL detect the rising edge of ack using a registered copy, and pop one entry and clear overrun on that edge only; a held-high ack pops once.
REQ-022 SHALL ignore an ack edge while empty: no state change, overrun still cleared.
REQ-023 SHALL, on capture while full, drop the new code, keep the stored contents, and set overrun.
REQ-024 SHALL, on capture and ack edge in the same cycle, perform the pop first, then the store; the stored code is not lost, overrun is not set, and valid stays 1.
REQ-025 SHALL make status and data reflect a capture or pop on the cycle after the event.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, set rowwrite=4'b1110, clear the divider and row index, enter IDLE, clear the debounce count, empty the store, set valid=0 and overrun=0, and clear the ack edge register.
REQ-027 SHALL abort any in-progress debounce or held key on reset; a key still pressed after reset SHALL be re-debounced and captured once.

Configuration
REQ-028 SHALL use macro KEYPAD_FIFO_EN: when defined, the store is a 4-entry FIFO with 2-bit pointers that wrap 3->0, valid = not empty, and full = 4 entries.
REQ-029 SHALL, when KEYPAD_FIFO_EN is undefined, use a single holding register, where valid = register occupied and full = valid.

Verification
REQ-030 Press key row1/col2 for 4 scans, SCAN_DIV=4, DEBOUNCE=3 -> status 4'b0001, data 4'h6, exactly one capture.
REQ-031 Bounce: hit, no-hit, hit, hit, hit -> capture only after the third consecutive hit; status 4'b0000 before that.
REQ-032 Hold ack high 10 cycles after a capture -> single pop; status 4'b0000 one cycle after the edge; data 4'h0.
REQ-033 Without KEYPAD_FIFO_EN: capture 4'h3, then capture 4'h9 without ack -> data 4'h3, status 4'b0011; ack -> status 4'b0000.
REQ-034 With KEYPAD_FIFO_EN: capture 1,2,3,4,5 -> status 4'b0011; successive acks read 1,2,3,4, then status 4'b0000.
REQ-035 Assert reset mid-DEBOUNCE with a stored key -> rowwrite 4'b1110, status 4'b0000 next cycle; the still-held key is captured once after DEBOUNCE scans.
